// File: rtl/velocity_cell_writer.sv
// velocity_cell_writer: writes a cell's particle velocities to RAM addresses 1..N, then the count to address 0.
// Optional macro VELOCITY_WB_CLEAR_TAIL_EN zeroes stale tail entries before the count is written.
module velocity_cell_writer #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  flush,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] count_out,
    output logic                  overflow
);

    // One extra pointer bit so "RAM full" (ptr == PARTICLE_NUM) is representable.
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(PARTICLE_NUM - 1);

`ifdef VELOCITY_WB_CLEAR_TAIL_EN
    typedef enum logic [2:0] {IDLE, WRITE, CLEAR, COMMIT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, COMMIT, DONE} state_t;
`endif

    state_t                state;
    logic [PW-1:0]         ptr;
    logic [ADDR_WIDTH-1:0] count;

    logic accept;
    logic room;
    logic close;

    // Beat qualification; a full RAM still accepts beats so upstream never stalls.
    always_comb begin
        accept = in_valid && in_ready;
        room   = (ptr <= LAST_PTR);
        close  = (state == WRITE) && ((accept && in_last) || flush);
    end

    assign mem_rden = 1'b0;

    // Cell write sequencer with registered RAM pins and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            count       <= '0;
            in_ready    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            count_out   <= '0;
            overflow    <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= PW'(1);
                        count    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept && room) begin
                        mem_address <= ptr[ADDR_WIDTH-1:0];
                        mem_data    <= in_data;
                        mem_wren    <= 1'b1;
                        ptr         <= ptr + PW'(1);
                        count       <= count + ADDR_WIDTH'(1);
                    end else if (accept) begin
                        overflow <= 1'b1;
                    end
                    if (close) begin
                        in_ready <= 1'b0;
                        if (accept) begin
                            // The beat's write occupies this edge; the
                            // count (or tail clear) follows next cycle.
`ifdef VELOCITY_WB_CLEAR_TAIL_EN
                            state <= (ptr < LAST_PTR) ? CLEAR : COMMIT;
`else
                            state <= COMMIT;
`endif
                        end else begin
                            // No beat pending: the RAM port is free now.
`ifdef VELOCITY_WB_CLEAR_TAIL_EN
                            if (room) begin
                                mem_address <= ptr[ADDR_WIDTH-1:0];
                                mem_data    <= '0;
                                mem_wren    <= 1'b1;
                                ptr         <= ptr + PW'(1);
                                state       <= (ptr == LAST_PTR) ? COMMIT : CLEAR;
                            end else begin
                                mem_address <= '0;
                                mem_data    <= DATA_WIDTH'(count);
                                mem_wren    <= 1'b1;
                                state       <= DONE;
                            end
`else
                            mem_address <= '0;
                            mem_data    <= DATA_WIDTH'(count);
                            mem_wren    <= 1'b1;
                            state       <= DONE;
`endif
                        end
                    end
                end
`ifdef VELOCITY_WB_CLEAR_TAIL_EN
                CLEAR: begin
                    mem_address <= ptr[ADDR_WIDTH-1:0];
                    mem_data    <= '0;
                    mem_wren    <= 1'b1;
                    ptr         <= ptr + PW'(1);
                    if (ptr == LAST_PTR) begin
                        state <= COMMIT;
                    end
                end
`endif
                COMMIT: begin
                    mem_address <= '0;
                    mem_data    <= DATA_WIDTH'(count);
                    mem_wren    <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done      <= 1'b1;
                    count_out <= count;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_cell_writer.sv
// tb_velocity_cell_writer: randomized and directed cells checked against a write-list model.
// Honours VELOCITY_WB_CLEAR_TAIL_EN the same way the design does.
module tb_velocity_cell_writer;

    localparam int P  = 8;
    localparam int AW = 8;
    localparam int DW = 96;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          flush;
    logic          in_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic          mem_rden;
    logic          busy;
    logic          done;
    logic [AW-1:0] count_out;
    logic          overflow;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    velocity_cell_writer #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(P),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .flush      (flush),
        .in_ready   (in_ready),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .busy       (busy),
        .done       (done),
        .count_out  (count_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every RAM write must be the next one the model predicts.
    always @(negedge clk) begin
        if (rst_n && mem_wren) begin
            check("write_expected", exp_q.size() != 0, 1);
            check("rden_low", mem_rden, 0);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_address, e.a);
                check("wr_data", mem_data, e.d);
            end
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic int tail_len(input int cnt);
`ifdef VELOCITY_WB_CLEAR_TAIL_EN
        return P - 1 - cnt;
`else
        return 0;
`endif
    endfunction

    task automatic push_close(input int cnt);
`ifdef VELOCITY_WB_CLEAR_TAIL_EN
        for (int a = cnt + 1; a <= P - 1; a++) begin
            exp_q.push_back({AW'(a), DW'(0)});
        end
`endif
        exp_q.push_back({AW'(0), DW'(cnt)});
    endtask

    // mode 0: in_last on final beat, 1: flush with final beat, 2: separate flush.
    // gap 0: back-to-back, 1: random gaps, 2: alternating gaps with stray start.
    task automatic run_cell(input int nb, input int mode_in, input int gap);
        int  mode;
        int  cnt;
        int  sent;
        int  cyc;
        int  lat;
        int  k;
        bit  ov;
        bit  g;
        logic [DW-1:0] d;
        mode = (nb == 0) ? 2 : mode_in;
        cnt = 0;
        sent = 0;
        cyc = 0;
        lat = 0;
        ov = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_after_start", busy, 1);
        check("ready_in_write", in_ready, 1);
        while (sent < nb && cyc < 500) begin
            if (gap == 1) g = ($urandom_range(0, 2) == 0);
            else if (gap == 2) g = cyc[0];
            else g = 0;
            if (g) begin
                in_valid = 0;
                in_last  = 1'($urandom_range(0, 1));
                start    = (gap == 2) || ($urandom_range(0, 3) == 0);
            end else begin
                d = rnd_word();
                in_valid = 1;
                in_data  = d;
                in_last  = (sent == nb - 1) && (mode == 0);
                flush    = (sent == nb - 1) && (mode == 1);
                if (cnt < P - 1) begin
                    exp_q.push_back({AW'(cnt + 1), d});
                    cnt++;
                end else begin
                    ov = 1;
                end
                sent++;
                if (sent == nb && mode != 2) begin
                    push_close(cnt);
                    lat = 3 + tail_len(cnt);
                end
            end
            cyc++;
            @(posedge clk); #1;
            in_valid = 0;
            in_last  = 0;
            flush    = 0;
            start    = 0;
            if (sent < nb || mode == 2) begin
                check("busy_mid_cell", busy, 1);
                check("ready_mid_cell", in_ready, 1);
            end
        end
        if (mode == 2) begin
            flush = 1;
            push_close(cnt);
            lat = 2 + tail_len(cnt);
            @(posedge clk); #1;
            flush = 0;
        end
        k = 1;
        while (!done && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_latency", k, lat);
        check("count_out", count_out, cnt);
        check("overflow", overflow, ov);
        check("busy_at_done", busy, 0);
        check("ready_at_done", in_ready, 0);
        check("writes_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("count_out_hold", count_out, cnt);
    endtask

    // Handshake inputs outside a cell must not produce writes.
    task automatic idle_noise();
        in_valid = 1;
        in_last  = 1;
        flush    = 1;
        in_data  = rnd_word();
        repeat (2) @(posedge clk);
        #1;
        in_valid = 0;
        in_last  = 0;
        flush    = 0;
        check("idle_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n    = 0;
        start    = 0;
        in_valid = 0;
        in_data  = '0;
        in_last  = 0;
        flush    = 0;
        #12;
        check("rst_wren", mem_wren, 0);
        check("rst_addr", mem_address, 0);
        check("rst_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 0);
        check("rst_count", count_out, 0);
        check("rst_ovf", overflow, 0);
        #5;
        rst_n = 1;
        @(posedge clk); #1;

        run_cell(3, 0, 0);
        run_cell(0, 2, 0);
        run_cell(10, 0, 0);
        run_cell(4, 0, 2);
        run_cell(P - 1, 0, 0);
        run_cell(2, 1, 0);
        idle_noise();

        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 2; i++) begin
            d = rnd_word();
            in_valid = 1;
            in_data  = d;
            exp_q.push_back({AW'(i + 1), d});
            @(posedge clk); #1;
        end
        in_valid = 0;
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("mid_rst_wren", mem_wren, 0);
        check("mid_rst_addr", mem_address, 0);
        check("mid_rst_data", mem_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_count", count_out, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_writes", exp_q.size(), 0);
        #2;
        rst_n = 1;
        @(posedge clk); #1;
        run_cell(1, 0, 0);

        for (int c = 0; c < 25; c++) begin
            run_cell($urandom_range(0, 11), $urandom_range(0, 2), 1);
            if ($urandom_range(0, 3) == 0) idle_noise();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
